// File: rtl/mmio_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mmio_ctrl_if : processor data-port bus into the MMIO controller   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface mmio_ctrl_if #(
    parameter int DBITS = 16
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] din;
    logic             we;
    logic             sel;
    logic [DBITS-1:0] dout;

    modport master (output addr, output din, output we, input sel, input dout);
    modport slave  (input addr, input din, input we, output sel, output dout);
endinterface
`default_nettype wire

// File: rtl/mmio_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mmio_ctrl : I/O region decode, display registers, KEY/SW debounce,|
// |             sticky key flags and prescaled interval timer        |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module mmio_ctrl #(
    parameter int DBITS      = 16,
    parameter int DEB_BITS   = 18,
    parameter int DEB_CYCLES = 250000,
    parameter int TICK_DIV   = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    mmio_ctrl_if.slave        bus,
    input  logic [3:0]        key_i,
    input  logic [9:0]        sw_i,
    output logic [15:0]       hex_o,
    output logic [9:0]        ledr_o,
    output logic [7:0]        ledg_o
);
    localparam int                  NDEB     = 14;
    localparam int                  PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_CYCLES - 1);
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(TICK_DIV - 1);

    localparam logic [2:0] REG_KDATA = 3'd0;
    localparam logic [2:0] REG_SDATA = 3'd1;
    localparam logic [2:0] REG_STAT  = 3'd2;
    localparam logic [2:0] REG_TCNT  = 3'd3;
    localparam logic [2:0] REG_HEX   = 3'd4;
    localparam logic [2:0] REG_LEDR  = 3'd5;
    localparam logic [2:0] REG_LEDG  = 3'd6;
    localparam logic [2:0] REG_TLIM  = 3'd7;

    // Bits [3:0] are keys in pressed polarity, [13:4] are switches.
    logic [NDEB-1:0]     sync1_q, sync2_q, stable_q, stable_d;
    logic [DEB_BITS-1:0] deb_cnt_q [NDEB];
    logic [DEB_BITS-1:0] deb_cnt_d [NDEB];
    logic [8:0]          stat_q, stat_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic [15:0]         tlim_q, tlim_d;
    logic [PS_W-1:0]     ps_q, ps_d;
    logic [15:0]         hex_q, hex_d;
    logic [9:0]          ledr_q, ledr_d;
    logic [7:0]          ledg_q, ledg_d;

    logic [NDEB-1:0]     raw;
    logic                sel;
    logic                wr;
    logic [2:0]          reg_idx;
    logic [3:0]          press;
    logic [8:0]          clr;
    logic                tick;
    logic                wrap;
    logic [15:0]         rdata;
    logic                unused_addr_lsb;

    assign raw             = {sw_i, ~key_i};
    assign sel             = (bus.addr[15:4] == 12'hFFF);
    assign wr              = bus.we && sel;
    assign reg_idx         = bus.addr[3:1];
    assign unused_addr_lsb = bus.addr[0];

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NDEB; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_BITS'(1);
                end
            end
        end
    end

    // A press in the same cycle as its W1C keeps the flag set and is not an overrun.
    always_comb begin
        press       = stable_d[3:0] & ~stable_q[3:0];
        clr         = (wr && reg_idx == REG_STAT) ? bus.din[8:0] : 9'd0;
        stat_d[3:0] = press | (stat_q[3:0] & ~clr[3:0]);
        stat_d[7:4] = (press & stat_q[3:0] & ~clr[3:0]) | (stat_q[7:4] & ~clr[7:4]);
        stat_d[8]   = wrap | (stat_q[8] & ~clr[8]);
    end

    always_comb begin
        tick   = (ps_q == PS_LAST);
        ps_d   = tick ? '0 : ps_q + PS_W'(1);
        tcnt_d = tcnt_q;
        wrap   = 1'b0;
        if (wr && reg_idx == REG_TCNT) begin
            tcnt_d = bus.din[15:0];
            ps_d   = '0;
        end else if (tick) begin
            if ((tlim_q != 16'd0 && tcnt_q == tlim_q) || tcnt_q == 16'hFFFF) begin
                tcnt_d = 16'd0;
                wrap   = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        hex_d  = hex_q;
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        tlim_d = tlim_q;
        if (wr) begin
            case (reg_idx)
                REG_HEX:  hex_d  = bus.din[15:0];
                REG_LEDR: ledr_d = bus.din[9:0];
                REG_LEDG: ledg_d = bus.din[7:0];
                REG_TLIM: tlim_d = bus.din[15:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        rdata = 16'd0;
        case (reg_idx)
            REG_KDATA: rdata = {12'd0, stable_q[3:0]};
            REG_SDATA: rdata = {6'd0, stable_q[13:4]};
            REG_STAT:  rdata = {7'd0, stat_q};
            REG_TCNT:  rdata = tcnt_q;
            REG_HEX:   rdata = hex_q;
            REG_LEDR:  rdata = {6'd0, ledr_q};
            REG_LEDG:  rdata = {8'd0, ledg_q};
            REG_TLIM:  rdata = tlim_q;
            default:   rdata = 16'd0;
        endcase
    end

    assign bus.sel  = sel;
    assign bus.dout = sel ? DBITS'(rdata) : '0;
    assign hex_o    = hex_q;
    assign ledr_o   = ledr_q;
    assign ledg_o   = ledg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < NDEB; i++) begin
                deb_cnt_q[i] <= '0;
            end
            stat_q   <= '0;
            tcnt_q   <= '0;
            tlim_q   <= '0;
            ps_q     <= '0;
            hex_q    <= '0;
            ledr_q   <= '0;
            ledg_q   <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < NDEB; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            stat_q   <= stat_d;
            tcnt_q   <= tcnt_d;
            tlim_q   <= tlim_d;
            ps_q     <= ps_d;
            hex_q    <= hex_d;
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
        end
    end
endmodule
`default_nettype wire
